// File: rtl/gradient_window_ctrl.sv
// Pixel-stream controller for a KERNEL_SIZE x KERNEL_SIZE gradient window: tracks frame
// position, issues shift/window strobes and throttles input by downstream result credits.
`timescale 1ns/1ps
module gradient_window_ctrl #(
   parameter int KERNEL_SIZE = 5,
   parameter int CREDITS     = 8,
   parameter int DIM_W       = 12
) (
   input  logic             i_clk,
   input  logic             i_aresetn,
   input  logic             i_enable,
   input  logic [DIM_W-1:0] i_cfg_width,
   input  logic [DIM_W-1:0] i_cfg_height,
   input  logic             i_pix_valid,
   input  logic             i_pix_sof,
   input  logic             i_pix_eol,
   output logic             o_pix_ready,
   output logic             o_shift_en,
   output logic             o_win_valid,
   output logic             o_win_sof,
   input  logic             i_credit_ret,
   output logic [DIM_W-1:0] o_row,
   output logic [DIM_W-1:0] o_col,
   output logic             o_busy,
   output logic             o_frame_done,
   output logic             o_err
);
   localparam int                CRED_W   = $clog2(CREDITS + 1);
   localparam logic [DIM_W-1:0]  K_LAST   = DIM_W'(KERNEL_SIZE - 1);
   localparam logic [DIM_W-1:0]  K_SIZE   = DIM_W'(KERNEL_SIZE);
   localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);

   typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE, DONE} state_t;

   state_t            state_reg, state_next;
   logic [DIM_W-1:0]  row_reg, row_next, col_reg, col_next;
   logic [DIM_W-1:0]  width_reg, width_next, height_reg, height_next;
   logic [CRED_W-1:0] credits_reg, credits_next;
   logic              win_valid_reg, win_valid_next, win_sof_reg, win_sof_next;
   logic              frame_done_reg, frame_done_next, err_reg, err_next;

   logic              pix_ready, accept, cfg_ok, frame_pix, restart, col_last;
   logic [DIM_W-1:0]  cur_row, cur_col, eff_width, eff_height;

   always_comb begin
      pix_ready = 1'b0;
      if (state_reg == WAIT_SOF) begin
         pix_ready = 1'b1;
      end else if (state_reg == ACTIVE) begin
         // The window issued last cycle has not been charged yet; count it as spent.
         pix_ready = credits_reg > CRED_W'(win_valid_reg);
      end
      accept     = i_pix_valid & pix_ready;
      cfg_ok     = (i_cfg_width >= K_SIZE) && (i_cfg_height >= K_SIZE);
      restart    = (state_reg == ACTIVE) & i_pix_sof;
      frame_pix  = accept & ((state_reg == ACTIVE) | i_pix_sof) & (~i_pix_sof | cfg_ok);
      cur_row    = i_pix_sof ? '0 : row_reg;
      cur_col    = i_pix_sof ? '0 : col_reg;
      eff_width  = i_pix_sof ? i_cfg_width : width_reg;
      eff_height = i_pix_sof ? i_cfg_height : height_reg;
      col_last   = (cur_col == eff_width - DIM_W'(1));
   end

   always_comb begin
      state_next      = state_reg;
      row_next        = row_reg;
      col_next        = col_reg;
      width_next      = width_reg;
      height_next     = height_reg;
      credits_next    = credits_reg;
      win_valid_next  = 1'b0;
      win_sof_next    = 1'b0;
      err_next        = 1'b0;
      frame_done_next = 1'b0;

      case (state_reg)
         IDLE: begin
            if (i_enable) state_next = WAIT_SOF;
         end
         WAIT_SOF, ACTIVE: begin
            if (accept & i_pix_sof) begin
               width_next  = i_cfg_width;
               height_next = i_cfg_height;
               err_next    = restart | ~cfg_ok;
               if (!cfg_ok) state_next = WAIT_SOF;
            end
            if (frame_pix) begin
               state_next     = ACTIVE;
               win_valid_next = ~restart & (cur_row >= K_LAST) & (cur_col >= K_LAST);
               win_sof_next   = ~restart & (cur_row == K_LAST) & (cur_col == K_LAST);
               if (i_pix_eol != col_last) err_next = 1'b1;
               // An early eol still closes the line, so the last line ends the frame.
               if (i_pix_eol | col_last) begin
                  col_next = '0;
                  row_next = cur_row + DIM_W'(1);
                  if (cur_row == eff_height - DIM_W'(1)) state_next = DONE;
               end else begin
                  col_next = cur_col + DIM_W'(1);
                  row_next = cur_row;
               end
            end
         end
         DONE:    state_next = WAIT_SOF;
         default: state_next = IDLE;
      endcase

      if (!i_enable) state_next = IDLE;
      if (state_next != ACTIVE) begin
         row_next = '0;
         col_next = '0;
      end
      frame_done_next = (state_next == DONE);

      if (i_credit_ret & ~win_valid_reg) begin
         if (credits_reg == CRED_MAX) err_next = 1'b1;
         else                         credits_next = credits_reg + CRED_W'(1);
      end else if (~i_credit_ret & win_valid_reg & (credits_reg != '0)) begin
         credits_next = credits_reg - CRED_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         state_reg      <= IDLE;
         row_reg        <= '0;
         col_reg        <= '0;
         width_reg      <= '0;
         height_reg     <= '0;
         credits_reg    <= CRED_MAX;
         win_valid_reg  <= 1'b0;
         win_sof_reg    <= 1'b0;
         frame_done_reg <= 1'b0;
         err_reg        <= 1'b0;
      end else begin
         state_reg      <= state_next;
         row_reg        <= row_next;
         col_reg        <= col_next;
         width_reg      <= width_next;
         height_reg     <= height_next;
         credits_reg    <= credits_next;
         win_valid_reg  <= win_valid_next;
         win_sof_reg    <= win_sof_next;
         frame_done_reg <= frame_done_next;
         err_reg        <= err_next;
      end
   end

   assign o_pix_ready  = pix_ready;
   assign o_shift_en   = frame_pix;
   assign o_win_valid  = win_valid_reg;
   assign o_win_sof    = win_sof_reg;
   assign o_row        = row_reg;
   assign o_col        = col_reg;
   assign o_busy       = (state_reg == ACTIVE) || (state_reg == DONE);
   assign o_frame_done = frame_done_reg;
   assign o_err        = err_reg;
endmodule

// File: tb/tb_gradient_window_ctrl.sv
// Bench for gradient_window_ctrl: frame-level reference model checked every cycle on the
// default instance, plus directed literal checks and a CREDITS=2 instance for stalling.
`timescale 1ns/1ps
module tb_gradient_window_ctrl;
   localparam int K = 5, A_CREDITS = 8, B_CREDITS = 2, DIM_W = 12;

   logic clk = 1'b0, rstn = 1'b0;
   logic a_en = 1'b0, b_en = 1'b0, sel = 1'b0, a_ret = 1'b0, b_ret = 1'b0;
   logic pix_valid = 1'b0, pix_sof = 1'b0, pix_eol = 1'b0;
   logic [DIM_W-1:0] cfg_w = 12'd8, cfg_h = 12'd6;
   logic a_valid, b_valid;
   logic a_ready, a_shift, a_win, a_wsof, a_busy, a_done, a_err;
   logic b_ready, b_shift, b_win, b_wsof, b_busy, b_done, b_err;
   logic [DIM_W-1:0] a_row, a_col, b_row, b_col;

   assign a_valid = pix_valid & ~sel;
   assign b_valid = pix_valid & sel;

   always #5 clk = ~clk;

   gradient_window_ctrl #(.KERNEL_SIZE(K), .CREDITS(A_CREDITS), .DIM_W(DIM_W)) dut (
      .i_clk(clk), .i_aresetn(rstn), .i_enable(a_en), .i_cfg_width(cfg_w), .i_cfg_height(cfg_h),
      .i_pix_valid(a_valid), .i_pix_sof(pix_sof), .i_pix_eol(pix_eol), .o_pix_ready(a_ready),
      .o_shift_en(a_shift), .o_win_valid(a_win), .o_win_sof(a_wsof), .i_credit_ret(a_ret),
      .o_row(a_row), .o_col(a_col), .o_busy(a_busy), .o_frame_done(a_done), .o_err(a_err));

   gradient_window_ctrl #(.KERNEL_SIZE(K), .CREDITS(B_CREDITS), .DIM_W(DIM_W)) dut_b (
      .i_clk(clk), .i_aresetn(rstn), .i_enable(b_en), .i_cfg_width(cfg_w), .i_cfg_height(cfg_h),
      .i_pix_valid(b_valid), .i_pix_sof(pix_sof), .i_pix_eol(pix_eol), .o_pix_ready(b_ready),
      .o_shift_en(b_shift), .o_win_valid(b_win), .o_win_sof(b_wsof), .i_credit_ret(b_ret),
      .o_row(b_row), .o_col(b_col), .o_busy(b_busy), .o_frame_done(b_done), .o_err(b_err));

   int n_cmp = 0, n_fail = 0;
   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model of instance A. Modes: 0 idle, 1 waiting for sof, 2 in frame, 3 frame done.
   int m_mode = 0, m_row = 0, m_col = 0, m_w = 0, m_h = 0, m_cred = A_CREDITS;
   bit m_win = 0, m_wsof = 0, m_done = 0, m_err = 0;

   function automatic bit m_ready_f();
      return (m_mode == 1) || (m_mode == 2 && (m_cred - int'(m_win)) > 0);
   endfunction

   function automatic bit m_shift_f();
      bit ok = (int'(cfg_w) >= K) && (int'(cfg_h) >= K);
      if (!(a_valid && m_ready_f())) return 1'b0;
      if (m_mode == 2) return !(pix_sof && !ok);
      return pix_sof && ok;
   endfunction

   task automatic model_step();
      bit win = 0, wsof = 0, err = 0, nowin = 0;
      bit acc = a_valid && m_ready_f();
      int pr = m_row, pc = m_col;
      int d = int'(a_ret) - int'(m_win);
      if (m_cred + d > A_CREDITS) err = 1; else m_cred += d;
      if (m_mode == 0) begin
         if (a_en) m_mode = 1;
      end else if (m_mode == 3) begin
         m_mode = 1;
      end else if (acc && (pix_sof || m_mode == 2)) begin
         if (pix_sof) begin
            if (m_mode == 2) begin err = 1; nowin = 1; end
            m_w = int'(cfg_w); m_h = int'(cfg_h); pr = 0; pc = 0;
            if (m_w < K || m_h < K) begin err = 1; m_mode = 1; end
            else m_mode = 2;
         end
         if (m_mode == 2) begin
            if (pr >= K-1 && pc >= K-1 && !nowin) begin win = 1; wsof = (pr == K-1 && pc == K-1); end
            if (pix_eol != (pc == m_w-1)) err = 1;
            if (pix_eol || pc == m_w-1) begin
               if (pr == m_h-1) m_mode = 3;
               pr++; pc = 0;
            end else pc++;
            m_row = pr; m_col = pc;
         end
      end
      if (!a_en) m_mode = 0;
      if (m_mode != 2) begin m_row = 0; m_col = 0; end
      m_done = (m_mode == 3);
      m_win = win; m_wsof = wsof; m_err = err;
   endtask

   initial forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
         m_mode = 0; m_row = 0; m_col = 0; m_w = 0; m_h = 0; m_cred = A_CREDITS;
         m_win = 0; m_wsof = 0; m_done = 0; m_err = 0;
      end else model_step();
   end

   // Event tallies for the directed checks.
   int win_cnt, wsof_cnt, done_cnt, err_cnt, shift_cnt, b_win_cnt, b_err_cnt;
   bit first_wsof;
   task automatic clear_counts();
      win_cnt = 0; wsof_cnt = 0; done_cnt = 0; err_cnt = 0; shift_cnt = 0;
      b_win_cnt = 0; b_err_cnt = 0; first_wsof = 0;
   endtask

   initial forever begin
      @(negedge clk); #2;
      check("ready", a_ready, m_ready_f());
      check("shift_en", a_shift, m_shift_f());
      check("win_valid", a_win, m_win);
      check("win_sof", a_wsof, m_wsof);
      check("frame_done", a_done, m_done);
      check("err", a_err, m_err);
      check("busy", a_busy, (m_mode == 2 || m_mode == 3));
      check("row", a_row, m_row);
      check("col", a_col, m_col);
      if (a_win && win_cnt == 0) first_wsof = a_wsof;
      win_cnt += a_win; wsof_cnt += a_wsof; done_cnt += a_done; err_cnt += a_err;
      shift_cnt += a_shift; b_win_cnt += b_win; b_err_cnt += b_err;
   end

   // Instance A returns one credit the cycle after each window.
   bit prev_w = 0;
   initial forever begin
      @(negedge clk);
      a_ret = prev_w;
      prev_w = a_win;
   end

   logic [1:0] pix_q[$];   // {sof, eol}
   int eol_r = -1, eol_c = -1, acc_idx = 0, probe_idx = -1, probe_row = 0, probe_col = 0;

   task automatic push_rows(input int w, input int r0, input int c0, input int sr, input int sc);
      int r = r0, c = c0;
      while (!(r == sr && c == sc)) begin
         bit eol = (c == w-1) || (r == eol_r && c == eol_c);
         pix_q.push_back({(r == 0 && c == 0), eol});
         if (eol) begin r++; c = 0; end else c++;
      end
   endtask

   task automatic drain(input int bound, output bit stalled);
      stalled = 0;
      while (pix_q.size() > 0) begin
         logic [1:0] p = pix_q[0];
         bit acc = 0;
         for (int k = 0; k < bound && !acc; k++) begin
            @(negedge clk);
            pix_valid = 1'b1; pix_sof = p[1]; pix_eol = p[0];
            #3 acc = sel ? b_ready : a_ready;
            @(posedge clk);
         end
         if (!acc) begin
            stalled = 1;
            @(negedge clk); pix_valid = 1'b0; pix_sof = 1'b0; pix_eol = 1'b0;
            return;
         end
         void'(pix_q.pop_front());
         if (acc_idx == probe_idx) begin
            #1;
            check("probe_row", a_row, probe_row);
            check("probe_col", a_col, probe_col);
         end
         acc_idx++;
      end
      @(negedge clk); pix_valid = 1'b0; pix_sof = 1'b0; pix_eol = 1'b0;
   endtask

   task automatic run_a(input string tag, input int exp_err);
      bit st;
      acc_idx = 0;
      drain(50, st);
      check({tag, "_stall"}, st, 0);
      repeat (6) @(negedge clk);
      check({tag, "_windows"}, win_cnt, 8);
      check({tag, "_first_sof"}, first_wsof, 1);
      check({tag, "_sof_cnt"}, wsof_cnt, 1);
      check({tag, "_done"}, done_cnt, 1);
      check({tag, "_errs"}, err_cnt, exp_err);
      $display("frame %s: windows=%0d done=%0d errs=%0d", tag, win_cnt, done_cnt, err_cnt);
   endtask

   initial begin
      bit st;
      repeat (3) @(negedge clk);
      #3;
      check("rst_ready", a_ready, 0); check("rst_busy", a_busy, 0);
      check("rst_row", a_row, 0); check("rst_col", a_col, 0);
      check("rst_win", a_win, 0); check("rst_err", a_err, 0);
      @(negedge clk); rstn = 1'b1;
      repeat (2) @(negedge clk);
      #3 check("idle_ready", a_ready, 0);
      @(negedge clk); a_en = 1'b1;
      repeat (2) @(negedge clk);
      #3 check("waitsof_ready", a_ready, 1);
      check("waitsof_busy", a_busy, 0);

      // Basic 8x6 frame
      clear_counts(); push_rows(8, 0, 0, 6, 0); run_a("basic", 0);

      // Junk before sof is swallowed without shifting
      clear_counts();
      repeat (3) pix_q.push_back(2'b00);
      drain(50, st);
      repeat (2) @(negedge clk);
      check("junk_shift", shift_cnt, 0);
      check("junk_err", err_cnt, 0);
      $display("junk: shifts=%0d", shift_cnt);
      clear_counts(); push_rows(8, 0, 0, 6, 0); run_a("after_junk", 0);

      // Early eol at row 2 col 5
      clear_counts(); eol_r = 2; eol_c = 5;
      probe_idx = 21; probe_row = 3; probe_col = 0;
      push_rows(8, 0, 0, 6, 0); run_a("early_eol", 1);
      eol_r = -1; eol_c = -1;

      // sof at row 3 col 4 restarts the frame
      clear_counts();
      probe_idx = 28; probe_row = 0; probe_col = 1;
      push_rows(8, 0, 0, 3, 4); pix_q.push_back(2'b10); push_rows(8, 0, 1, 6, 0);
      run_a("mid_sof", 1);
      probe_idx = -1;

      // Undersized config is rejected
      clear_counts(); cfg_w = 12'd4; cfg_h = 12'd6;
      pix_q.push_back(2'b10); drain(50, st);
      repeat (2) @(negedge clk);
      #3;
      check("badcfg_err", err_cnt, 1); check("badcfg_shift", shift_cnt, 0);
      check("badcfg_busy", a_busy, 0); check("badcfg_ready", a_ready, 1);
      $display("bad cfg: errs=%0d shifts=%0d", err_cnt, shift_cnt);

      // Asynchronous reset in the middle of a frame
      cfg_w = 12'd8; cfg_h = 12'd6;
      push_rows(8, 0, 0, 2, 3); drain(50, st);
      @(negedge clk); pix_valid = 1'b1;
      #3;
      check("pre_rst_busy", a_busy, 1); check("pre_rst_shift", a_shift, 1);
      rstn = 1'b0;
      #1;
      check("arst_ready", a_ready, 0); check("arst_shift", a_shift, 0);
      check("arst_busy", a_busy, 0); check("arst_win", a_win, 0);
      check("arst_done", a_done, 0); check("arst_err", a_err, 0);
      check("arst_row", a_row, 0); check("arst_col", a_col, 0);
      $display("async reset: busy=%0d ready=%0d row=%0d", a_busy, a_ready, a_row);
      pix_valid = 1'b0;
      repeat (2) @(negedge clk); rstn = 1'b1;
      repeat (3) @(negedge clk);

      // CREDITS=2 instance, no credit return
      sel = 1'b1; b_en = 1'b1;
      repeat (2) @(negedge clk);
      clear_counts(); push_rows(8, 0, 0, 6, 0);
      drain(20, st);
      check("b_stall1", st, 1); check("b_windows1", b_win_cnt, 2);
      check("b_left1", pix_q.size(), 10); check("b_ready_low", b_ready, 0);
      $display("credit stall: windows=%0d pending=%0d", b_win_cnt, pix_q.size());
      @(negedge clk); b_ret = 1'b1;
      @(negedge clk); b_ret = 1'b0;
      drain(20, st);
      check("b_stall2", st, 1); check("b_windows2", b_win_cnt, 3);
      check("b_left2", pix_q.size(), 9); check("b_errs", b_err_cnt, 0);
      $display("credit return: windows=%0d pending=%0d", b_win_cnt, pix_q.size());
      pix_q.delete();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/gradient_window_ctrl.md
GRADIENT_WINDOW_CTRL -- requirements
Module: gradient_window_ctrl

Interface
REQ-001 Parameters SHALL be: KERNEL_SIZE, default 5, window edge length; CREDITS, default 8, downstream result-buffer depth; DIM_W, default 12, width of frame-dimension and counter fields.
REQ-002 Ports SHALL be (name direction width meaning):
- i_clk in 1: clock.
- i_aresetn in 1: reset, asynchronous, active-low.
- i_enable in 1: controller enable.
- i_cfg_width in DIM_W: frame width in pixels.
- i_cfg_height in DIM_W: frame height in lines.
- i_pix_valid in 1: input pixel valid.
- i_pix_sof in 1: first pixel of frame.
- i_pix_eol in 1: last pixel of line.
- o_pix_ready out 1: pixel accepted when valid&ready.
- o_shift_en out 1: advance line buffers and window.
- o_win_valid out 1: window valid to Gx/Gy stage.
- o_win_sof out 1: first window of frame.
- i_credit_ret in 1: downstream consumed one result.
- o_row out DIM_W: current row.
- o_col out DIM_W: current column.
- o_busy out 1: frame in progress.
- o_frame_done out 1: one-cycle pulse at frame end.
- o_err out 1: one-cycle protocol-error pulse.

Function
REQ-003 FSM states SHALL be IDLE, WAIT_SOF, ACTIVE, DONE; i_enable low in any state SHALL force IDLE on the next edge; IDLE->WAIT_SOF when i_enable high.
REQ-004 In WAIT_SOF, o_pix_ready SHALL be 1. Pixels without sof are discarded with no shift and no window.
REQ-005 An accepted sof pixel in WAIT_SOF SHALL latch i_cfg_width/i_cfg_height, be treated as pixel (0,0), and enter ACTIVE.
- If the latched width or height < KERNEL_SIZE: pulse o_err, no shift, stay in WAIT_SOF.
REQ-006 o_shift_en SHALL equal i_pix_valid & o_pix_ready while in ACTIVE, or while in WAIT_SOF with an accepted valid sof pixel; it is combinational.
REQ-007 In ACTIVE, o_pix_ready SHALL be 1 only when the credit counter > 0.
REQ-008 Each accepted pixel SHALL advance the position:
- col+1 normally.
- col=0 and row+1 when col==width-1.
REQ-009 The pixel accepted at (row,col) with row>=KERNEL_SIZE-1 and col>=KERNEL_SIZE-1 SHALL assert o_win_valid exactly one cycle after acceptance (registered).
- o_win_sof SHALL assert alongside it only for (KERNEL_SIZE-1, KERNEL_SIZE-1).
REQ-010 Credit counter (0..CREDITS):
- Reset value CREDITS.
- -1 per o_win_valid; +1 per i_credit_ret; both in the same cycle leave it unchanged.
- Increment at CREDITS is saturated and pulses o_err.
REQ-011 Accepting pixel (height-1, width-1) SHALL move to DONE.
- DONE lasts one cycle with o_pix_ready=0, pulses o_frame_done, then goes to WAIT_SOF.
REQ-012 An accepted eol with col!=width-1 SHALL pulse o_err and force col=0, row+1.
- col==width-1 without eol SHALL pulse o_err and wrap normally.
REQ-013 An accepted sof in ACTIVE SHALL pulse o_err and restart the frame: that pixel becomes (0,0) with cfg relatched, and no window is issued for it.
REQ-014 o_busy SHALL be 1 in ACTIVE and DONE. o_row/o_col SHALL show the position of the next expected pixel.
REQ-015 Credits SHALL persist across frames and across IDLE (pending downstream results remain valid).

Reset
REQ-016 On i_aresetn low:
- FSM=IDLE; row=col=0; credits=CREDITS.
- o_pix_ready, o_shift_en, o_win_valid, o_win_sof, o_busy, o_frame_done, o_err = 0.
- Cfg latches = 0.
REQ-017 Reset mid-frame SHALL abort immediately. After release, the block requires enable plus a fresh sof.

Verification
REQ-018 Basic frame: enable, 8x6 frame streamed continuously, i_credit_ret tied 1 one cycle after each window -> exactly 8 o_win_valid, the first with o_win_sof, 1 o_frame_done, o_err never.
REQ-019 Credit stall: CREDITS=2, 8x6 frame, no credit return -> o_pix_ready drops after the second window and stays 0 until i_credit_ret pulses; then exactly one more window.
REQ-020 Pre-sof junk: 3 valid non-sof pixels, then an 8x6 frame -> junk discarded with no o_shift_en; frame output identical to REQ-018.
REQ-021 Early eol: 8-wide frame with eol at col 5 on row 2 -> o_err pulse, next pixel at row 3 col 0, frame still ends with o_frame_done.
REQ-022 Sof mid-frame: sof at row 3 col 4 -> o_err pulse, o_row=0 and o_col=1 after it, window count restarts.
REQ-023 Bad config: width 4, height 6, sof -> o_err pulse, state WAIT_SOF, no o_shift_en; async reset mid-frame -> all outputs 0 in the same cycle.
